dmem_hs: RTL and testbench

- Parametrised successor to the single-cycle data memory: word-organised RAM with byte/half/word access, sign/zero-extended loads, and a request/response handshake with configurable wait-state latency.
- Sits between the core's load/store unit and storage, so the same RAM serves both single-cycle and multi-cycle/pipelined cores.
- One outstanding transaction at a time.

---
 rtl/dmem_hs.sv | 247 ++++++++++++++++++++++++
 tb/tb_dmem_hs.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_hs.sv
`timescale 1ns/1ps
// dmem_hs: word-organised data RAM with byte/half/word access, sign/zero
// extended loads and a valid/ready request/response handshake with LATENCY
// wait cycles. One transaction is in flight at a time.
// Optional build macro: DMEM_STATS_EN adds load_count/store_count outputs.
module dmem_hs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]           load_count,
    output logic [31:0]           store_count
`endif
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam int         LOW_W     = IDX_W + 2;
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY == 0 ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             accept;
    logic             enter_resp;
    logic             req_err;

    // Fields captured at acceptance; only the in-range address bits matter.
    logic [LOW_W-1:0] cap_addr;
    logic [1:0]       cap_size;
    logic             cap_unsigned;
    logic             cap_write;
    logic             cap_err;

    // Fields used by the read on the edge entering RESP.
    logic [LOW_W-1:0] rd_addr;
    logic [1:0]       rd_size;
    logic             rd_unsigned;
    logic             rd_write;
    logic             rd_err;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data_q;

    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    logic [31:0]      mem [DEPTH];

    // Illegal size, misalignment, or an address beyond the last word.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [1:0]            size);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr[0];
            2'd2:    bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad || ((addr >> LOW_W) != '0);
    endfunction

    // Select the addressed byte/half and extend it to 32 bits.
    function automatic logic [31:0] extend(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [1:0]  size,
                                           input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req_err    = addr_err(req_addr, req_size);
    assign req_ready  = (state_q == IDLE);
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // Next-state logic: accept in IDLE, count wait cycles, hold RESP until taken.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !rst) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_valid && resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-side field select: with LATENCY=0 RESP is entered straight from IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            rd_addr     = req_addr[LOW_W-1:0];
            rd_size     = req_size;
            rd_unsigned = req_unsigned;
            rd_write    = req_write;
            rd_err      = req_err;
        end else begin
            rd_addr     = cap_addr;
            rd_size     = cap_size;
            rd_unsigned = cap_unsigned;
            rd_write    = cap_write;
            rd_err      = cap_err;
        end
        rd_word = mem[rd_addr[LOW_W-1:2]];
    end

    // Store lane enables and lane-replicated write data; errors write nothing.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        case (req_size)
            2'd0: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: wr_be = 4'b1111;
        endcase
        if (!(accept && req_write && !req_err)) begin
            wr_be = 4'b0000;
        end
    end

    // RAM write on the acceptance edge, byte lanes individually enabled.
    // NOTE: the storage array has no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[req_addr[LOW_W-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture, load read/extend, and the registered response stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr     <= '0;
            cap_size     <= 2'd0;
            cap_unsigned <= 1'b0;
            cap_write    <= 1'b0;
            cap_err      <= 1'b0;
            ld_data_q    <= 32'd0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_error   <= 1'b0;
        end else begin
            if (accept) begin
                cap_addr     <= req_addr[LOW_W-1:0];
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_write    <= req_write;
                cap_err      <= req_err;
            end
            if (enter_resp) begin
                ld_data_q <= (rd_write || rd_err) ? 32'd0
                           : extend(rd_word, rd_addr[1:0], rd_size, rd_unsigned);
            end
            // First RESP cycle registers the read data; it then holds until taken.
            if (state_q == RESP && !resp_valid) begin
                resp_valid <= 1'b1;
                resp_rdata <= ld_data_q;
                resp_error <= cap_err;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef DMEM_STATS_EN
    // Count accepted non-error loads and stores; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count  <= 32'd0;
            store_count <= 32'd0;
        end else if (accept && !req_err) begin
            if (req_write) begin
                store_count <= store_count + 32'd1;
            end else begin
                load_count <= load_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_hs.sv
`timescale 1ns/1ps
// tb_dmem_hs: directed vectors for dmem_hs. A driver pushes the expected
// response for each request; a monitor pops and compares on each handshake.
// A second instance with LATENCY=3 covers abort-by-reset during WAIT.
module tb_dmem_hs;

    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (LATENCY=1)
    logic        rst, req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_error;
    // Second instance (LATENCY=3)
    logic        rst_3, req_valid_3, req_ready_3, req_write_3, req_unsigned_3;
    logic [31:0] req_addr_3, req_wdata_3, resp_rdata_3;
    logic [1:0]  req_size_3;
    logic        resp_valid_3, resp_ready_3, resp_error_3;
`ifdef DMEM_STATS_EN
    logic [31:0] load_count, store_count, load_count_3, store_count_3;
`endif

    dmem_hs #(.ADDR_WIDTH(32), .DEPTH(1024), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
`ifdef DMEM_STATS_EN
        , .load_count(load_count), .store_count(store_count)
`endif
    );

    dmem_hs #(.ADDR_WIDTH(32), .DEPTH(1024), .LATENCY(LAT3)) u_dut3 (
        .clk(clk), .rst(rst_3),
        .req_valid(req_valid_3), .req_ready(req_ready_3), .req_write(req_write_3),
        .req_addr(req_addr_3), .req_size(req_size_3), .req_unsigned(req_unsigned_3),
        .req_wdata(req_wdata_3), .resp_valid(resp_valid_3), .resp_ready(resp_ready_3),
        .resp_rdata(resp_rdata_3), .resp_error(resp_error_3)
`ifdef DMEM_STATS_EN
        , .load_count(load_count_3), .store_count(store_count_3)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_loads  = 0;
    int exp_stores = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;

    // Issue one request to the main instance and record its expected response.
    task automatic issue(input string name, input logic w, input logic [31:0] a,
                         input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee);
        exp_t e;
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check({name, " ready timeout"}, {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid    = 1'b1;
        req_write    = w;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        e.rdata = er;
        e.err   = ee;
        e.acc   = cyc;
        e.name  = name;
        sb.push_back(e);
        if (!ee) begin
            if (w) exp_stores++;
            else   exp_loads++;
        end
        // Fields are don't-care after acceptance: scramble them.
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) check("drain timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: checks rise latency and pops/compares on each response handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (sb.size() == 0) check("unexpected resp_valid", {31'd0, resp_valid}, 32'd0);
                else check({sb[0].name, " latency"}, 32'(cyc - sb[0].acc), 32'(LAT + 1));
            end
            if (resp_valid && resp_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                check({mon_e.name, " rdata"}, resp_rdata, mon_e.rdata);
                check({mon_e.name, " error"}, {31'd0, resp_error}, {31'd0, mon_e.err});
            end
            prev_valid <= resp_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   acc3;
        logic seen;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b1;
        rst_3 = 1'b1; req_valid_3 = 1'b0; req_write_3 = 1'b0; req_addr_3 = '0;
        req_size_3 = 2'd0; req_unsigned_3 = 1'b0; req_wdata_3 = '0; resp_ready_3 = 1'b1;

        repeat (3) @(negedge clk);
        check("reset req_ready",  {31'd0, req_ready},  32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata,          32'd0);
        check("reset resp_error", {31'd0, resp_error}, 32'd0);
        rst   = 1'b0;
        rst_3 = 1'b0;

        //    name            w     addr           sz  uns  wdata          exp rdata      err
        issue("st w 0x10",    1'b1, 32'h10,        2,  0,   32'hDEADBEEF,  32'h0,         0);
        issue("ld w 0x10",    1'b0, 32'h10,        2,  1,   32'h0,         32'hDEADBEEF,  0);
        issue("st w 0x20",    1'b1, 32'h20,        2,  0,   32'h0,         32'h0,         0);
        issue("st b 0x21",    1'b1, 32'h21,        0,  0,   32'h12345680,  32'h0,         0);
        issue("st h 0x22",    1'b1, 32'h22,        1,  0,   32'hABCD8001,  32'h0,         0);
        issue("ld w 0x20",    1'b0, 32'h20,        2,  0,   32'h0,         32'h80018000,  0);
        issue("ld sb 0x21",   1'b0, 32'h21,        0,  0,   32'h0,         32'hFFFFFF80,  0);
        issue("ld ub 0x21",   1'b0, 32'h21,        0,  1,   32'h0,         32'h00000080,  0);
        issue("ld sh 0x22",   1'b0, 32'h22,        1,  0,   32'h0,         32'hFFFF8001,  0);
        issue("ld uh 0x22",   1'b0, 32'h22,        1,  1,   32'h0,         32'h00008001,  0);
        issue("ld sb 0x22",   1'b0, 32'h22,        0,  0,   32'h0,         32'h00000001,  0);
        issue("ld sb 0x23",   1'b0, 32'h23,        0,  0,   32'h0,         32'hFFFFFF80,  0);
        issue("st w 0x13 mis",1'b1, 32'h13,        2,  0,   32'h11111111,  32'h0,         1);
        issue("ld w 0x10 old",1'b0, 32'h10,        2,  0,   32'h0,         32'hDEADBEEF,  0);
        issue("ld w oob",     1'b0, 32'h1000,      2,  0,   32'h0,         32'h0,         1);
        issue("ld size3",     1'b0, 32'h10,        3,  0,   32'h0,         32'h0,         1);
        issue("st size3",     1'b1, 32'h10,        3,  0,   32'h22222222,  32'h0,         1);
        issue("ld h 0x11 mis",1'b0, 32'h11,        1,  0,   32'h0,         32'h0,         1);
        issue("st b oob",     1'b1, 32'h1000,      0,  0,   32'h000000AA,  32'h0,         1);
        issue("st w 0xFFC",   1'b1, 32'hFFC,       2,  0,   32'h01020304,  32'h0,         0);
        issue("ld w 0xFFC",   1'b0, 32'hFFC,       2,  0,   32'h0,         32'h01020304,  0);
        issue("ld sb 0xFFF",  1'b0, 32'hFFF,       0,  0,   32'h0,         32'h00000001,  0);
        issue("ld uh 0xFFE",  1'b0, 32'hFFE,       1,  1,   32'h0,         32'h00000102,  0);
        issue("ld w 0x10 fin",1'b0, 32'h10,        2,  0,   32'h0,         32'hDEADBEEF,  0);
        drain();

        // Backpressure: response held for 5 cycles; a request offered meanwhile is dropped.
        @(posedge clk); #1 resp_ready = 1'b0;
        issue("bp ld w 0x20", 1'b0, 32'h20, 2, 0, 32'h0, 32'h80018000, 0);
        t = 0;
        @(negedge clk);
        while (!resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp resp seen", {31'd0, resp_valid}, 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 2'd2;
        req_wdata = 32'h55555555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp resp_valid held", {31'd0, resp_valid}, 32'd1);
            check("bp resp_rdata held", resp_rdata,          32'h80018000);
            check("bp req_ready low",   {31'd0, req_ready},  32'd0);
        end
        req_valid = 1'b0;
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post-hs req_ready",  {31'd0, req_ready},  32'd1);
        check("post-hs resp_valid", {31'd0, resp_valid}, 32'd0);
        issue("ld w 0x20 after bp", 1'b0, 32'h20, 2, 0, 32'h0, 32'h80018000, 0);
        drain();

        // LATENCY=3 instance: store, then abort a load with reset during WAIT.
        @(negedge clk);
        check("d3 req_ready idle", {31'd0, req_ready_3}, 32'd1);
        req_valid_3 = 1'b1; req_write_3 = 1'b1; req_addr_3 = 32'h40;
        req_size_3 = 2'd2; req_wdata_3 = 32'hCAFEF00D;
        @(posedge clk); #1 req_valid_3 = 1'b0;
        t = 0;
        @(negedge clk);
        while (!resp_valid_3 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("d3 store resp", {31'd0, resp_valid_3}, 32'd1);
        @(negedge clk);
        req_valid_3 = 1'b1; req_write_3 = 1'b0; req_addr_3 = 32'h40; req_size_3 = 2'd2;
        @(posedge clk); #1 req_valid_3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_3 = 1'b1;
        seen  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | resp_valid_3;
        end
        rst_3 = 1'b0;
        check("d3 req_ready after rst", {31'd0, req_ready_3}, 32'd1);
        repeat (8) begin
            @(negedge clk);
            seen = seen | resp_valid_3;
        end
        check("d3 aborted no resp", {31'd0, seen}, 32'd0);
        req_valid_3 = 1'b1; req_write_3 = 1'b0; req_addr_3 = 32'h40; req_size_3 = 2'd2;
        req_unsigned_3 = 1'b0;
        @(posedge clk); #1 req_valid_3 = 1'b0;
        acc3 = cyc;
        t = 0;
        @(negedge clk);
        while (!resp_valid_3 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("d3 reload latency", 32'(cyc - acc3), 32'(LAT3 + 1));
        check("d3 reload rdata",   resp_rdata_3,              32'hCAFEF00D);
        check("d3 reload error",   {31'd0, resp_error_3},     32'd0);
        @(negedge clk);

`ifdef DMEM_STATS_EN
        drain();
        check("load_count",  load_count,  32'(exp_loads));
        check("store_count", store_count, 32'(exp_stores));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("load_count rst",  load_count,  32'd0);
        check("store_count rst", store_count, 32'd0);
        rst = 1'b0;
`endif

        drain();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
